// File: rtl/issue_unit_pkg.sv
// Shared issue-stage definitions: unit latencies, unit selector and divider FSM states.
package issue_unit_pkg;

    localparam int INT_LAT      = 1;
    localparam int LS_LAT       = 1;
    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 7;

    typedef enum logic [1:0] {
        UNIT_INT,
        UNIT_LS,
        UNIT_MULT,
        UNIT_DIV
    } unit_e;

    typedef enum logic {
        DIV_IDLE,
        DIV_BUSY
    } div_state_e;

    // Divider countdown width: enough to hold the latency, never below 3 bits.
    function automatic int div_cnt_width(input int lat);
        return ($clog2(lat + 1) < 3) ? 3 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/cdb_reservation.sv
// CDB reservation shift register: bit i set means the bus is claimed i cycles from now.
module cdb_reservation #(
    parameter int WIDTH   = 8,
    parameter int NUM_CHK = 4,
    parameter int LW      = $clog2(WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CHK-1:0][LW-1:0]    chk_lat,
    output logic [NUM_CHK-1:0]            chk_free,
    input  logic                          ins_en,
    input  logic [LW-1:0]                 ins_lat,
    output logic [WIDTH-1:0]              res
);

    logic [WIDTH-1:0] ins_mask;

    // A result issued now with latency L is L-1 cycles away once this edge has passed.
    always_comb begin
        ins_mask = '0;
        if (ins_en)
            ins_mask = WIDTH'(1) << (ins_lat - LW'(1));
    end

    always_comb begin
        chk_free = '0;
        for (int k = 0; k < NUM_CHK; k++)
            chk_free[k] = ~res[chk_lat[k]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res <= '0;
        else
            res <= (res >> 1) | ins_mask;
    end

endmodule

// File: rtl/issue_unit.sv
// Issue-stage scheduler: grants at most one ready queue per cycle without CDB collisions.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             int_ready,
    input  logic             ls_ready,
    input  logic             mult_ready,
    input  logic             div_ready,
    input  logic             flush,
    output logic             issue_int,
    output logic             issue_ls,
    output logic             issue_mult,
    output logic             issue_div,
    output logic             div_busy,
    output logic [DIV_LAT:0] cdb_res
);

    localparam int RW = DIV_LAT + 1;
    localparam int LW = $clog2(RW);
    localparam int CW = div_cnt_width(DIV_LAT);

    localparam logic [LW-1:0] L_INT  = LW'(INT_LAT);
    localparam logic [LW-1:0] L_LS   = LW'(LS_LAT);
    localparam logic [LW-1:0] L_MULT = LW'(MULT_LAT);
    localparam logic [LW-1:0] L_DIV  = LW'(DIV_LAT);

    logic [3:0][LW-1:0] chk_lat;
    logic [3:0]         slot_free;
    logic [LW-1:0]      ins_lat;
    logic               gnt_valid;
    unit_e              gnt_unit;
    logic               can_issue;
    logic               elig_int, elig_ls, elig_mult, elig_div;
    logic               rr;
    div_state_e         div_state, div_state_next;
    logic [CW-1:0]      div_cnt, div_cnt_next;

    assign chk_lat = {L_DIV, L_MULT, L_LS, L_INT};

    cdb_reservation #(
        .WIDTH   (RW),
        .NUM_CHK (4),
        .LW      (LW)
    ) u_res (
        .clk      (clk),
        .rst_n    (rst_n),
        .chk_lat  (chk_lat),
        .chk_free (slot_free),
        .ins_en   (gnt_valid),
        .ins_lat  (ins_lat),
        .res      (cdb_res)
    );

    // Grants stay low while reset is held so every output reads zero during reset.
    assign can_issue = rst_n & ~flush;
    assign elig_int  = int_ready  & slot_free[0] & can_issue;
    assign elig_ls   = ls_ready   & slot_free[1] & can_issue;
    assign elig_mult = mult_ready & slot_free[2] & can_issue;
    assign elig_div  = div_ready  & slot_free[3] & can_issue & ~div_busy;

    always_comb begin
        gnt_valid = 1'b1;
        gnt_unit  = UNIT_INT;
        if (elig_div)
            gnt_unit = UNIT_DIV;
        else if (elig_mult)
            gnt_unit = UNIT_MULT;
        else if (elig_int && elig_ls)
            gnt_unit = rr ? UNIT_LS : UNIT_INT;
        else if (elig_int)
            gnt_unit = UNIT_INT;
        else if (elig_ls)
            gnt_unit = UNIT_LS;
        else
            gnt_valid = 1'b0;
    end

    always_comb begin
        issue_int  = gnt_valid && (gnt_unit == UNIT_INT);
        issue_ls   = gnt_valid && (gnt_unit == UNIT_LS);
        issue_mult = gnt_valid && (gnt_unit == UNIT_MULT);
        issue_div  = gnt_valid && (gnt_unit == UNIT_DIV);
        case (gnt_unit)
            UNIT_LS:   ins_lat = L_LS;
            UNIT_MULT: ins_lat = L_MULT;
            UNIT_DIV:  ins_lat = L_DIV;
            default:   ins_lat = L_INT;
        endcase
    end

    // The pointer only moves when int and ls actually contended and one of them won.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr <= 1'b0;
        else if (issue_int && elig_ls)
            rr <= 1'b1;
        else if (issue_ls && elig_int)
            rr <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
        end else begin
            div_state <= div_state_next;
            div_cnt   <= div_cnt_next;
        end
    end

    // Leaving BUSY as the count hits zero frees the divider in its result's CDB cycle.
    always_comb begin
        div_state_next = div_state;
        div_cnt_next   = div_cnt;
        case (div_state)
            DIV_IDLE: begin
                if (issue_div) begin
                    div_state_next = DIV_BUSY;
                    div_cnt_next   = CW'(DIV_LAT - 1);
                end
            end
            DIV_BUSY: begin
                div_cnt_next = div_cnt - CW'(1);
                if (div_cnt == CW'(1))
                    div_state_next = DIV_IDLE;
            end
            default: div_state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_busy = (div_state == DIV_BUSY);
    end

endmodule
